// File: rtl/bouncing_box_renderer.sv
// -----------------------------------------------------------------------------
// bouncing_box_renderer
//
// Pixel-colour source that sits just upstream of the VGA driver. It draws a
// solid rectangle over a background colour. Once per frame it moves the
// rectangle one step, bounces it off the screen edges, counts the bounces and
// flashes the rectangle for a few frames after each bounce.
//
// Ports:
//   clk_25mhz    in   1   pixel clock
//   reset        in   1   synchronous, active-high
//   pixel_x      in  10   x of the pixel being drawn
//   pixel_y      in  10   y of the pixel being drawn
//   active       in   1   high during the visible area
//   move_en      in   1   high: rectangle moves each frame; low: frozen
//   bg_color     in   8   background colour (RRRGGGBB)
//   color_out    out  8   registered pixel colour (one cycle latency)
//   frame_tick   out  1   one-cycle pulse once per frame
//   box_x        out 10   rectangle left edge
//   box_y        out 10   rectangle top edge
//   bounce_count out  8   total bounces, wraps at 256
// -----------------------------------------------------------------------------
module bouncing_box_renderer #(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          BOX_W        = 32,
  parameter int          BOX_H        = 32,
  parameter int          STEP         = 2,
  parameter logic [7:0]  BOX_COLOR    = 8'hE0,
  parameter logic [7:0]  FLASH_COLOR  = 8'hFF,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       active,
  input  logic       move_en,
  input  logic [7:0] bg_color,
  output logic [7:0] color_out,
  output logic       frame_tick,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic [7:0] bounce_count
);

  // All position arithmetic is done 11 bits wide so sums never wrap.
  localparam logic [10:0] X_MAX      = 11'(H_ACTIVE - BOX_W);
  localparam logic [10:0] Y_MAX      = 11'(V_ACTIVE - BOX_H);
  localparam logic [10:0] STEP_W     = 11'(STEP);
  localparam logic [10:0] BOX_W_W    = 11'(BOX_W);
  localparam logic [10:0] BOX_H_W    = 11'(BOX_H);
  localparam logic [9:0]  X_INIT     = 10'((H_ACTIVE - BOX_W) / 2);
  localparam logic [9:0]  Y_INIT     = 10'((V_ACTIVE - BOX_H) / 2);
  localparam logic [9:0]  LAST_X     = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  LAST_Y     = 10'(V_ACTIVE - 1);
  localparam logic [7:0]  FLASH_INIT = 8'(FLASH_FRAMES);

  logic [7:0] color_q, color_d;
  logic       frame_tick_q, frame_tick_d;
  logic       detect_q, detect_d;
  logic [9:0] box_x_q, box_x_d;
  logic [9:0] box_y_q, box_y_d;
  logic       dir_x_q, dir_x_d;   // 1 = moving right
  logic       dir_y_q, dir_y_d;   // 1 = moving down
  logic [7:0] bounce_count_q, bounce_count_d;
  logic [7:0] flash_q, flash_d;

  logic        detect;
  logic        in_box;
  logic [10:0] x_sum, y_sum;
  logic [9:0]  step_x, step_y;
  logic        step_dir_x, step_dir_y;
  logic        hit_x, hit_y;
  logic        bounce;

  // Last visible pixel of the frame; the tick fires on its rising edge only so
  // a held input produces a single pulse until the condition drops again.
  always_comb begin
    detect       = active && (pixel_x == LAST_X) && (pixel_y == LAST_Y);
    detect_d     = detect;
    frame_tick_d = detect && !detect_q;
  end

  // Colour for the pixel currently presented, registered at the next edge.
  always_comb begin
    in_box = ({1'b0, pixel_x} >= {1'b0, box_x_q}) &&
             ({1'b0, pixel_x} <  ({1'b0, box_x_q} + BOX_W_W)) &&
             ({1'b0, pixel_y} >= {1'b0, box_y_q}) &&
             ({1'b0, pixel_y} <  ({1'b0, box_y_q} + BOX_H_W));
    if (!active) begin
      color_d = 8'h00;
    end else if (in_box) begin
      color_d = (flash_q != 8'd0) ? FLASH_COLOR : BOX_COLOR;
    end else begin
      color_d = bg_color;
    end
  end

  // Candidate next position per axis, with clamping against the screen edge
  // so the rectangle never leaves the visible area.
  always_comb begin
    x_sum      = {1'b0, box_x_q} + STEP_W;
    step_x     = box_x_q;
    step_dir_x = dir_x_q;
    hit_x      = 1'b0;
    if (dir_x_q) begin
      if (x_sum >= X_MAX) begin
        step_x     = X_MAX[9:0];
        step_dir_x = 1'b0;
        hit_x      = 1'b1;
      end else begin
        step_x = x_sum[9:0];
      end
    end else begin
      if ({1'b0, box_x_q} <= STEP_W) begin
        step_x     = 10'd0;
        step_dir_x = 1'b1;
        hit_x      = 1'b1;
      end else begin
        step_x = box_x_q - STEP_W[9:0];
      end
    end

    y_sum      = {1'b0, box_y_q} + STEP_W;
    step_y     = box_y_q;
    step_dir_y = dir_y_q;
    hit_y      = 1'b0;
    if (dir_y_q) begin
      if (y_sum >= Y_MAX) begin
        step_y     = Y_MAX[9:0];
        step_dir_y = 1'b0;
        hit_y      = 1'b1;
      end else begin
        step_y = y_sum[9:0];
      end
    end else begin
      if ({1'b0, box_y_q} <= STEP_W) begin
        step_y     = 10'd0;
        step_dir_y = 1'b1;
        hit_y      = 1'b1;
      end else begin
        step_y = box_y_q - STEP_W[9:0];
      end
    end
  end

  // Frame update happens at the edge that ends the tick cycle, so the new
  // position is first drawn in the following frame. The flash counter keeps
  // running when frozen; a corner hit still counts as a single bounce.
  always_comb begin
    box_x_d        = box_x_q;
    box_y_d        = box_y_q;
    dir_x_d        = dir_x_q;
    dir_y_d        = dir_y_q;
    bounce_count_d = bounce_count_q;
    flash_d        = flash_q;
    bounce         = move_en && (hit_x || hit_y);
    if (frame_tick_q) begin
      if (move_en) begin
        box_x_d = step_x;
        box_y_d = step_y;
        dir_x_d = step_dir_x;
        dir_y_d = step_dir_y;
      end
      if (bounce) begin
        bounce_count_d = bounce_count_q + 8'd1;
        flash_d        = FLASH_INIT;
      end else if (flash_q != 8'd0) begin
        flash_d = flash_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      color_q        <= 8'h00;
      frame_tick_q   <= 1'b0;
      detect_q       <= 1'b0;
      box_x_q        <= X_INIT;
      box_y_q        <= Y_INIT;
      dir_x_q        <= 1'b1;
      dir_y_q        <= 1'b1;
      bounce_count_q <= 8'd0;
      flash_q        <= 8'd0;
    end else begin
      color_q        <= color_d;
      frame_tick_q   <= frame_tick_d;
      detect_q       <= detect_d;
      box_x_q        <= box_x_d;
      box_y_q        <= box_y_d;
      dir_x_q        <= dir_x_d;
      dir_y_q        <= dir_y_d;
      bounce_count_q <= bounce_count_d;
      flash_q        <= flash_d;
    end
  end

  assign color_out    = color_q;
  assign frame_tick   = frame_tick_q;
  assign box_x        = box_x_q;
  assign box_y        = box_y_q;
  assign bounce_count = bounce_count_q;

endmodule
